// File: rtl/riscv_mem_pkg.sv
// Shared load/store encodings for the core's data port and the memory responder.
// Size codes match the core's store-mask and load-extend logic bit for bit.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10,
    MEM_X = 2'b11
  } MEM_SIZE;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } MEM_STATE;

endpackage

// File: rtl/riscv_mem_lane.sv
// Byte-lane steering for the data port: store data/byte-enable alignment and load extraction/extension.
// Purely combinational; no handshake of its own.
module riscv_mem_lane
  import riscv_mem_pkg::*;
(
  input  logic [31:0] i_wdata,
  input  MEM_SIZE     i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_unsigned,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword,
  output logic [31:0] o_rdata
);

  // Replicating the right-aligned data across the word lets the byte enables pick the lane.
  function automatic logic [35:0] store_align(input logic [31:0] wdata, input MEM_SIZE size,
                                              input logic [1:0] lo);
    logic [3:0]  be;
    logic [31:0] word;
    be   = 4'b0000;
    word = 32'h0;
    case (size)
      MEM_B:   begin be = 4'b0001 << lo;             word = {4{wdata[7:0]}};  end
      MEM_H:   begin be = lo[1] ? 4'b1100 : 4'b0011; word = {2{wdata[15:0]}}; end
      MEM_W:   begin be = 4'b1111;                   word = wdata;            end
      default: begin be = 4'b0000;                   word = 32'h0;            end
    endcase
    return {be, word};
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input MEM_SIZE size,
                                               input logic [1:0] lo, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {lo, 3'b000});
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      MEM_B:   r = {{24{~uns & b[7]}}, b};
      MEM_H:   r = {{16{~uns & h[15]}}, h};
      MEM_W:   r = word;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  assign {o_be, o_wword} = store_align(i_wdata, i_size, i_addr_lo);
  assign o_rdata         = load_extract(i_rword, i_size, i_addr_lo, i_unsigned);

endmodule

// File: rtl/riscv_mem_responder.sv
// Single-outstanding load/store responder over a word array with programmable wait states.
// A request accepted at edge T is answered after edge T+1+WAIT_CYCLES; the response holds until rsp_ready.
module riscv_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        x_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IDXW     = $clog2(DEPTH_WORDS);
  localparam int          CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [CW-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  MEM_STATE      r_state;
  logic [CW-1:0] r_cnt;
  logic          r_write;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  MEM_SIZE       r_size;
  logic          r_unsigned;
  logic          r_req_ready;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_rdata;
  logic          r_rsp_err;

  logic [31:0]   r_mem [DEPTH_WORDS];

  logic [32:0]   w_off;
  logic [IDXW-1:0] w_idx;
  logic          w_misalign;
  logic          w_err;
  logic          w_commit;
  logic [3:0]    w_be;
  logic [31:0]   w_wword;
  logic [31:0]   w_rword;
  logic [31:0]   w_rdata;

  // An address below the base borrows into bit 32, so a single unsigned compare covers both bounds.
  assign w_off      = {1'b0, r_addr} - {1'b0, BASE_ADDR};
  assign w_idx      = w_off[IDXW+1:2];
  assign w_misalign = ((r_size == MEM_H) && r_addr[0]) ||
                      ((r_size == MEM_W) && (r_addr[1:0] != 2'b00));
  assign w_err      = (r_size == MEM_X) || w_misalign || (w_off >= SPAN);
  assign w_commit   = (r_state == RESP) && !r_rsp_valid;
  assign w_rword    = r_mem[w_idx];

  riscv_mem_lane u_lane (
    .i_wdata    (r_wdata),
    .i_size     (r_size),
    .i_addr_lo  (r_addr[1:0]),
    .i_unsigned (r_unsigned),
    .i_rword    (w_rword),
    .o_be       (w_be),
    .o_wword    (w_wword),
    .o_rdata    (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (w_commit && r_write && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
      end
    end
  end

  // The first RESP cycle is the commit cycle; rsp_valid rises on the edge that leaves it.
  always_ff @(posedge clk or negedge x_reset) begin
    if (!x_reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_size      <= MEM_B;
      r_unsigned  <= 1'b0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_req_ready && req_valid) begin
            r_write     <= req_write;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_size      <= MEM_SIZE'(req_size);
            r_unsigned  <= req_unsigned;
            r_req_ready <= 1'b0;
            r_cnt       <= CNT_INIT;
            r_state     <= (WAIT_CYCLES > 0) ? WAIT : RESP;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (r_cnt == '0) r_state <= RESP;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        RESP: begin
          if (!r_rsp_valid) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (w_err || r_write) ? 32'h0 : w_rdata;
          end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
